lsh_band_bucket: RTL and testbench

Downstream consumer of the per-window MinHash signature stage. Accepts one S-word signature plus its window index. Splits the signature into S/R bands of R rows and hashes each band to a bucket key. Looks the key up in a per-band bucket table and reports a candidate pair (previous window, current window) on every tag match, then records the current window in that bucket.

---
 rtl/lsh_band_bucket.sv | 187 ++++++++++++++++++
 tb/tb_lsh_band_bucket.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsh_band_bucket.sv
// LSH band bucketing stage: splits a captured MinHash signature into bands,
// hashes each band to a bucket key, and looks it up in that band's table.
// A tag match emits a (prev window, cur window) candidate pair; every band
// then records the current window in its bucket.
module lsh_band_bucket #(
    parameter int S        = 4,
    parameter int R        = 2,
    parameter int TBL_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                sig_valid,
    output logic                sig_ready,
    input  logic [S-1:0][31:0]  sig,
    input  logic [31:0]         w_i,
    output logic                cand_valid,
    input  logic                cand_ready,
    output logic [31:0]         cand_band,
    output logic [31:0]         cand_prev_wi,
    output logic [31:0]         cand_cur_wi,
    output logic                done,
    output logic [15:0]         evict_cnt
);
    localparam int NB = S / R;
    localparam int NE = 1 << TBL_BITS;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        IDLE, CLEAR, CAPTURE, HASH, LOOKUP, EMIT, WRITE, DONE
    } state_t;

    state_t               state;
    logic                 rdy_q;      // low only in the first cycle after reset and outside IDLE
    logic [S-1:0][31:0]   sig_q;
    logic [31:0]          wi_q;
    logic [31:0]          key_q;
    logic [BW-1:0]        b_q;
    logic [TBL_BITS-1:0]  idx_q;
    logic [TBL_BITS-1:0]  clr_idx;

    logic [NE-1:0]        tbl_vld [NB];
    logic [31:0]          tbl_tag [NB][NE];
    logic [31:0]          tbl_wi  [NB][NE];

    logic [NB-1:0][31:0]  band_key;
    logic [31:0]          key_c;
    logic [TBL_BITS-1:0]  idx_c;
    logic                 rd_vld;
    logic [31:0]          rd_tag;
    logic [31:0]          rd_wi;
    logic                 hit;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    // Band keys: XOR of each row rotated left by 8 bits per row position
    for (genvar gb = 0; gb < NB; gb++) begin : g_band
        logic [R:0][31:0] acc;
        assign acc[0] = '0;
        for (genvar gr = 0; gr < R; gr++) begin : g_row
            assign acc[gr+1] = acc[gr] ^ rotl(sig_q[gb*R+gr], 8*gr);
        end
        assign band_key[gb] = acc[R];
    end

    assign key_c = band_key[b_q];
    assign idx_c = key_c[TBL_BITS-1:0] ^ key_c[31:32-TBL_BITS];

    // Table read uses the index registered in HASH
    assign rd_vld = tbl_vld[b_q][idx_q];
    assign rd_tag = tbl_tag[b_q][idx_q];
    assign rd_wi  = tbl_wi[b_q][idx_q];
    assign hit    = rd_vld && (rd_tag == key_q);

    assign sig_ready = rdy_q && !clear;

    // Per-band tables: valid bits reset/cleared, tag and window payload written in WRITE
    for (genvar gb = 0; gb < NB; gb++) begin : g_tbl
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                tbl_vld[gb] <= '0;
            end else if (state == CLEAR) begin
                tbl_vld[gb][clr_idx] <= 1'b0;
            end else if (state == WRITE && b_q == BW'(gb)) begin
                tbl_vld[gb][idx_q] <= 1'b1;
            end
        end

        // Payload needs no reset: it is only meaningful under a set valid bit
        always_ff @(posedge clk) begin
            if (state == WRITE && b_q == BW'(gb)) begin
                tbl_tag[gb][idx_q] <= key_q;
                tbl_wi[gb][idx_q]  <= wi_q;
            end
        end
    end

    // Control FSM with registered handshake, candidate and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rdy_q        <= 1'b0;
            sig_q        <= '0;
            wi_q         <= '0;
            key_q        <= '0;
            b_q          <= '0;
            idx_q        <= '0;
            clr_idx      <= '0;
            cand_valid   <= 1'b0;
            cand_band    <= '0;
            cand_prev_wi <= '0;
            cand_cur_wi  <= '0;
            done         <= 1'b0;
            evict_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rdy_q) begin
                        rdy_q <= 1'b1;
                    end else if (clear) begin
                        clr_idx <= '0;
                        rdy_q   <= 1'b0;
                        state   <= CLEAR;
                    end else if (sig_valid) begin
                        sig_q <= sig;
                        wi_q  <= w_i;
                        b_q   <= '0;
                        rdy_q <= 1'b0;
                        state <= CAPTURE;
                    end
                end
                CLEAR: begin
                    clr_idx <= clr_idx + TBL_BITS'(1);
                    if (clr_idx == TBL_BITS'(NE-1)) begin
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                CAPTURE: state <= HASH;
                HASH: begin
                    key_q <= key_c;
                    idx_q <= idx_c;
                    state <= LOOKUP;
                end
                LOOKUP: begin
                    if (hit) begin
                        cand_valid   <= 1'b1;
                        cand_band    <= 32'(b_q);
                        cand_prev_wi <= rd_wi;
                        cand_cur_wi  <= wi_q;
                        state        <= EMIT;
                    end else begin
                        if (rd_vld && evict_cnt != 16'hFFFF)
                            evict_cnt <= evict_cnt + 16'd1;
                        state <= WRITE;
                    end
                end
                EMIT: begin
                    if (cand_ready) begin
                        cand_valid <= 1'b0;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (b_q == BW'(NB-1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        b_q   <= b_q + BW'(1);
                        state <= HASH;
                    end
                end
                DONE: begin
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsh_band_bucket.sv
// Directed bench for lsh_band_bucket with a bucket-table reference model.
module tb_lsh_band_bucket;
    localparam int S  = 4;
    localparam int R  = 2;
    localparam int NB = S / R;
    localparam int NE = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clear = 1'b0;
    logic              sig_valid = 1'b0;
    logic              sig_ready;
    logic [S-1:0][31:0] sig = '0;
    logic [31:0]       w_i = '0;
    logic              cand_valid;
    logic              cand_ready = 1'b1;
    logic [31:0]       cand_band, cand_prev_wi, cand_cur_wi;
    logic              done;
    logic [15:0]       evict_cnt;

    always #5 clk = ~clk;

    lsh_band_bucket #(.S(S), .R(R), .TBL_BITS(4)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .sig_valid(sig_valid), .sig_ready(sig_ready), .sig(sig), .w_i(w_i),
        .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_band(cand_band), .cand_prev_wi(cand_prev_wi), .cand_cur_wi(cand_cur_wi),
        .done(done), .evict_cnt(evict_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: bucket tables as plain arrays
    bit          m_vld [NB][NE];
    logic [31:0] m_tag [NB][NE];
    logic [31:0] m_wi  [NB][NE];
    typedef struct { int band; logic [31:0] prev; logic [31:0] cur; } cand_t;
    cand_t expq[$];
    int exp_evict = 0;
    int exp_hits  = 0;

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic model_clear();
        for (int b = 0; b < NB; b++)
            for (int e = 0; e < NE; e++) m_vld[b][e] = 0;
    endtask

    task automatic model_sig(input logic [S-1:0][31:0] s, input logic [31:0] wi);
        logic [S*32-1:0] flat;
        logic [31:0] key;
        logic [3:0]  idx;
        cand_t c;
        flat = s;
        exp_hits = 0;
        for (int b = 0; b < NB; b++) begin
            key = '0;
            for (int r = 0; r < R; r++) key = key ^ rl(flat[(b*R+r)*32 +: 32], 8*r);
            idx = key[3:0] ^ key[31:28];
            if (m_vld[b][idx] && m_tag[b][idx] == key) begin
                c.band = b; c.prev = m_wi[b][idx]; c.cur = wi;
                expq.push_back(c);
                exp_hits++;
            end else if (m_vld[b][idx] && exp_evict < 65535) begin
                exp_evict++;
            end
            m_vld[b][idx] = 1;
            m_tag[b][idx] = key;
            m_wi[b][idx]  = wi;
        end
    endtask

    // Compare process: sampled on the falling edge
    int cyc = 0, acc = 0, stalls = 0, done_cnt = 0, last_lat = 0, hs_cnt = 0;
    bit busy = 0, prev_stall = 0;
    logic [31:0] pb, pp, pc;
    always @(negedge clk) begin
        bit accept;
        cand_t c;
        if (!reset) begin
            busy = 0;
            prev_stall = 0;
        end else begin
            cyc++;
            accept = sig_valid && sig_ready;
            if (!busy) begin
                chk("cand_valid_idle", 32'(cand_valid), 32'd0);
                chk("done_idle", 32'(done), 32'd0);
            end else begin
                chk("sig_ready_busy", 32'(sig_ready), 32'd0);
            end
            if (accept) begin
                acc = cyc; busy = 1; stalls = 0; prev_stall = 0;
                model_sig(sig, w_i);
            end
            if (busy && cand_valid) begin
                if (prev_stall) begin
                    chk("stall_band", cand_band, pb);
                    chk("stall_prev", cand_prev_wi, pp);
                    chk("stall_cur", cand_cur_wi, pc);
                end
                if (!cand_ready) begin
                    stalls++;
                    prev_stall = 1;
                    pb = cand_band; pp = cand_prev_wi; pc = cand_cur_wi;
                end else begin
                    prev_stall = 0;
                    hs_cnt++;
                    if (expq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_cand: got band %0d prev %0h cur %0h expected none",
                                 cand_band, cand_prev_wi, cand_cur_wi);
                    end else begin
                        c = expq.pop_front();
                        chk("cand_band", cand_band, 32'(c.band));
                        chk("cand_prev_wi", cand_prev_wi, c.prev);
                        chk("cand_cur_wi", cand_cur_wi, c.cur);
                    end
                end
            end
            if (busy && done) begin
                last_lat = cyc - acc;
                chk("done_latency", 32'(last_lat), 32'(2 + 3*NB + exp_hits + stalls));
                chk("cands_left", 32'(expq.size()), 32'd0);
                chk("evict_cnt", 32'(evict_cnt), 32'(exp_evict));
                busy = 0;
                done_cnt++;
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!sig_ready && n < 100) begin @(posedge clk); #2; n++; end
        if (!sig_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: got sig_ready 0 expected 1");
        end
    endtask

    task automatic send(input logic [31:0] a, b, c, d, input logic [31:0] wi,
                        input int stall_n, input bit wait_done);
        int n, sc, d0;
        wait_ready();
        sig[0] = a; sig[1] = b; sig[2] = c; sig[3] = d;
        w_i = wi;
        sig_valid = 1'b1;
        cand_ready = (stall_n == 0);
        d0 = done_cnt;
        @(posedge clk); #2;
        sig_valid = 1'b0;
        for (int i = 0; i < S; i++) sig[i] = $urandom;
        w_i = $urandom;
        if (wait_done) begin
            n = 0; sc = 0;
            while (done_cnt == d0 && n < 200) begin
                if (cand_valid && !cand_ready) begin
                    if (sc == stall_n) cand_ready = 1'b1;
                    else sc++;
                end
                @(posedge clk); #2;
                n++;
            end
            if (done_cnt == d0) begin
                n_cmp++; n_bad++;
                $display("FAIL done_timeout: got no done expected done");
            end
            cand_ready = 1'b1;
        end
    endtask

    task automatic do_clear(output int n);
        wait_ready();
        clear = 1'b1;
        model_clear();
        @(posedge clk); #2;
        clear = 1'b0;
        n = 0;
        while (!sig_ready && n < 100) begin n++; @(posedge clk); #2; end
    endtask

    initial begin
        int h0, nclr, d0;
        // 1: reset values and ready timing
        @(negedge clk); @(negedge clk);
        chk("rst_sig_ready", 32'(sig_ready), 32'd0);
        chk("rst_cand_valid", 32'(cand_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_evict", 32'(evict_cnt), 32'd0);
        chk("rst_cand_band", cand_band, 32'd0);
        chk("rst_cand_prev", cand_prev_wi, 32'd0);
        chk("rst_cand_cur", cand_cur_wi, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        chk("ready_before_edge", 32'(sig_ready), 32'd0);
        @(posedge clk); #2;
        chk("ready_after_release", 32'(sig_ready), 32'd1);

        // 2: cold insert
        h0 = hs_cnt;
        send(32'd1, 32'd2, 32'd3, 32'd4, 32'h10, 0, 1);
        chk("t2_latency", 32'(last_lat), 32'd8);
        chk("t2_cands", 32'(hs_cnt - h0), 32'd0);

        // 3: full repeat, two candidates
        h0 = hs_cnt;
        send(32'd1, 32'd2, 32'd3, 32'd4, 32'h20, 0, 1);
        chk("t3_latency", 32'(last_lat), 32'd10);
        chk("t3_cands", 32'(hs_cnt - h0), 32'd2);

        // 4: partial match with a 5-cycle consumer stall
        h0 = hs_cnt;
        send(32'd1, 32'd2, 32'd9, 32'd9, 32'h30, 5, 1);
        chk("t4_latency", 32'(last_lat), 32'd14);
        chk("t4_stalls", 32'(stalls), 32'd5);
        chk("t4_cands", 32'(hs_cnt - h0), 32'd1);

        // 5: eviction in band0 bucket 1, band1 key 0 repeats
        do_clear(nclr);
        send(32'h1, 32'd0, 32'd0, 32'd0, 32'h40, 0, 1);
        h0 = hs_cnt;
        send(32'h10000000, 32'd0, 32'd0, 32'd0, 32'h50, 0, 1);
        chk("t5_evict", 32'(evict_cnt), 32'd1);
        chk("t5_cands", 32'(hs_cnt - h0), 32'd1);

        // 6: clear duration, then reset during LOOKUP
        do_clear(nclr);
        chk("t6_clear_cycles", 32'(nclr), 32'd16);
        h0 = hs_cnt;
        send(32'd1, 32'd2, 32'd3, 32'd4, 32'h60, 0, 1);
        chk("t6_after_clear_cands", 32'(hs_cnt - h0), 32'd0);
        d0 = done_cnt;
        send(32'd1, 32'd2, 32'd3, 32'd4, 32'h70, 0, 0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        model_clear();
        expq.delete();
        exp_evict = 0;
        @(negedge clk);
        chk("midrst_cand_valid", 32'(cand_valid), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_evict", 32'(evict_cnt), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));
        h0 = hs_cnt;
        send(32'd1, 32'd2, 32'd3, 32'd4, 32'h80, 0, 1);
        chk("t6_model_empty", 32'(exp_hits), 32'd0);
        chk("t6_after_rst_cands", 32'(hs_cnt - h0), 32'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
endmodule
